// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: admits whole camera frames into the sobel engine, holds its threshold per frame,
// counts output edge pixels, flags malformed frames and optionally steers the threshold per frame.
module sobel_frame_ctrl #(
  parameter logic [8:0]  IMG_HDISP = 9'd320,
  parameter logic [7:0]  IMG_VDISP = 8'd240,
  parameter logic [7:0]  THR_INIT  = 8'd64,
  parameter logic [7:0]  THR_MIN   = 8'd16,
  parameter logic [7:0]  THR_MAX   = 8'd240,
  parameter logic [7:0]  THR_STEP  = 8'd4,
  parameter logic [16:0] TARGET_LO = 17'd3840,
  parameter logic [16:0] TARGET_HI = 17'd11520,
  parameter logic [15:0] DRAIN_MAX = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        auto_thr_en,
  input  logic [7:0]  cfg_threshold,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_clken,
  input  logic [7:0]  in_img,
  output logic        out_vsync,
  output logic        out_href,
  output logic        out_clken,
  output logic [7:0]  out_img,
  output logic [7:0]  sobel_threshold,
  input  logic        post_vsync,
  input  logic        post_href,
  input  logic        post_clken,
  input  logic        post_bit,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [16:0] edge_count,
  output logic [15:0] frame_cnt
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3;
  localparam logic [16:0] PIX_TOT = 17'(IMG_HDISP) * 17'(IMG_VDISP);
  logic [1:0]  state_q, state_d;
  logic        vs_d_q, pvs_d_q;
  logic        out_vsync_q, out_vsync_d, out_href_q, out_href_d, out_clken_q, out_clken_d;
  logic [7:0]  out_img_q, out_img_d, thr_q, thr_d, thr_auto_q, thr_auto_d;
  logic [16:0] pix_acc_q, pix_acc_d, edge_acc_q, edge_acc_d, edge_count_q, edge_count_d;
  logic [15:0] drain_q, drain_d, frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic        run, drain, fs, fe, close, tmo, cnt_err, pix_v, enter_run;
  logic [8:0]  up9, dn9;
  logic [7:0]  thr_up, thr_dn, thr_next;
  always_comb begin
    run = state_q == S_RUN;
    drain = state_q == S_DRAIN;
    fs = vs_d_q & ~in_vsync;
    fe = ~vs_d_q & in_vsync;
    close = drain & ~pvs_d_q & post_vsync;
    tmo = drain & ~close & (drain_q == DRAIN_MAX - 16'd1);
    cnt_err = pix_acc_q != PIX_TOT;
    pix_v = (run | drain) & post_href & post_clken;
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = enable ? S_ARM : S_IDLE;
      S_ARM:   state_d = !enable ? S_IDLE : in_vsync ? S_RUN : S_ARM;
      S_RUN:   state_d = fe ? S_DRAIN : S_RUN;
      default: state_d = (close | tmo) ? (enable ? S_ARM : S_IDLE) : S_DRAIN;
    endcase
    enter_run = (state_q == S_ARM) & (state_d == S_RUN);
    pix_acc_d = enter_run ? 17'd0 : (pix_v && pix_acc_q != '1) ? pix_acc_q + 17'd1 : pix_acc_q;
    edge_acc_d = enter_run ? 17'd0 : (pix_v && post_bit && edge_acc_q != '1) ? edge_acc_q + 17'd1 : edge_acc_q;
    drain_d = (run & fe) ? 16'd0 : drain ? drain_q + 16'd1 : drain_q;
    out_vsync_d = run ? in_vsync : 1'b1;
    out_href_d = run & in_href;
    out_clken_d = run & in_clken;
    out_img_d = run ? in_img : 8'd0;
    thr_d = (run & fs) ? (auto_thr_en ? thr_auto_q : cfg_threshold) : thr_q;
    // 9-bit step arithmetic so neither direction can wrap past the clamp bounds
    up9 = {1'b0, thr_auto_q} + {1'b0, THR_STEP};
    dn9 = {1'b0, thr_auto_q} - {1'b0, THR_STEP};
    thr_up = (up9 > {1'b0, THR_MAX}) ? THR_MAX : up9[7:0];
    thr_dn = (dn9[8] || dn9[7:0] < THR_MIN) ? THR_MIN : dn9[7:0];
    thr_next = !auto_thr_en ? cfg_threshold : (edge_acc_q > TARGET_HI) ? thr_up :
               (edge_acc_q < TARGET_LO) ? thr_dn : thr_auto_q;
    thr_auto_d = (close & ~cnt_err) ? thr_next : thr_auto_q;
    edge_count_d = close ? edge_acc_q : edge_count_q;
    frame_cnt_d = frame_cnt_q + {15'd0, close};
    frame_done_d = close;
    frame_err_d = (close & cnt_err) | tmo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vs_d_q <= 1'b1;
      pvs_d_q <= 1'b1;
      out_vsync_q <= 1'b1;
      out_href_q <= 1'b0;
      out_clken_q <= 1'b0;
      out_img_q <= 8'd0;
      thr_q <= THR_INIT;
      thr_auto_q <= THR_INIT;
      pix_acc_q <= 17'd0;
      edge_acc_q <= 17'd0;
      drain_q <= 16'd0;
      edge_count_q <= 17'd0;
      frame_cnt_q <= 16'd0;
      frame_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d_q <= in_vsync;
      pvs_d_q <= post_vsync;
      out_vsync_q <= out_vsync_d;
      out_href_q <= out_href_d;
      out_clken_q <= out_clken_d;
      out_img_q <= out_img_d;
      thr_q <= thr_d;
      thr_auto_q <= thr_auto_d;
      pix_acc_q <= pix_acc_d;
      edge_acc_q <= edge_acc_d;
      drain_q <= drain_d;
      edge_count_q <= edge_count_d;
      frame_cnt_q <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign out_vsync = out_vsync_q;
  assign out_href = out_href_q;
  assign out_clken = out_clken_q;
  assign out_img = out_img_q;
  assign sobel_threshold = thr_q;
  assign busy = state_q != S_IDLE;
  assign frame_done = frame_done_q;
  assign frame_err = frame_err_q;
  assign edge_count = edge_count_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: 8x4 frames through sobel_frame_ctrl with a 6-cycle delayed post side and a result scoreboard.
module tb_sobel_frame_ctrl;
  localparam int TLO = 2, THI = 10;
  logic clk = 0, rst, enable, auto_thr_en;
  logic [7:0] cfg_threshold, in_img, out_img, sobel_threshold;
  logic in_vsync, in_href, in_clken, out_vsync, out_href, out_clken;
  logic post_vsync, post_href, post_clken, post_bit, busy, frame_done, frame_err;
  logic [16:0] edge_count;
  logic [15:0] frame_cnt;
  logic [5:0] pv = '1, ph = '0, pc = '0, pb = '0;
  logic hold_pv = 0;
  typedef struct {bit done; bit err; int ec; int cnt;} res_t;
  res_t res_q[$];
  int thr_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, t_rise = 0, pass_err = 0, href_seen = 0;
  int m_cnt = 0, m_ec = 0, m_thr = 64, last_thr = 0;
  bit pass_exp = 0, watch = 0, ov_prev = 1;
  logic [10:0] prev_in = '0;

  sobel_frame_ctrl #(.IMG_HDISP(9'd8), .IMG_VDISP(8'd4), .TARGET_LO(17'(TLO)), .TARGET_HI(17'(THI))) dut (
    .clk(clk), .rst(rst), .enable(enable), .auto_thr_en(auto_thr_en), .cfg_threshold(cfg_threshold),
    .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken), .in_img(in_img),
    .out_vsync(out_vsync), .out_href(out_href), .out_clken(out_clken), .out_img(out_img),
    .sobel_threshold(sobel_threshold), .post_vsync(post_vsync), .post_href(post_href),
    .post_clken(post_clken), .post_bit(post_bit), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .edge_count(edge_count), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    pv <= {pv[4:0], out_vsync};
    ph <= {ph[4:0], out_href};
    pc <= {pc[4:0], out_clken};
    pb <= {pb[4:0], out_img[7]};
  end
  assign post_vsync = pv[5] & ~hold_pv;
  assign post_href = ph[5];
  assign post_clken = pc[5];
  assign post_bit = pb[5];

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int step_thr(input int t, input int e);
    if (e > THI) return (t + 4 > 240) ? 240 : t + 4;
    if (e < TLO) return (t - 4 < 16) ? 16 : t - 4;
    return t;
  endfunction

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    res_t r;
    cyc++;
    if (!rst) begin
      if (frame_done || frame_err) begin
        if (res_q.size() == 0) check("unexp_close", {frame_done, frame_err}, 0);
        else begin
          r = res_q.pop_front();
          check("frame_done", frame_done, r.done);
          check("frame_err", frame_err, r.err);
          check("edge_count", edge_count, r.ec);
          check("frame_cnt", frame_cnt, r.cnt);
          if (!r.done) check("tmo_latency_ok", int'((cyc - t_rise) inside {[4095:4097]}), 1);
        end
      end
      if (ov_prev && !out_vsync) begin
        if (thr_q.size() == 0) check("unexp_frame", 1, 0);
        else check("sobel_threshold", sobel_threshold, thr_q.pop_front());
      end
      if (!ov_prev && out_vsync) t_rise = cyc;
      if (pass_exp && {out_vsync, out_href, out_clken, out_img} != prev_in) pass_err++;
      if (watch && out_href) href_seen++;
    end
    ov_prev = out_vsync;
    prev_in = {in_vsync, in_href, in_clken, in_img};
  end

  task automatic drive_frame(input int n_edge, input bit drop, input bit admit, input bit tmo,
                             input bit mid_en, input int mid_cfg);
    int p = 0;
    bit err;
    repeat (12) cyc_step();
    if (admit) begin
      last_thr = auto_thr_en ? m_thr : int'(cfg_threshold);
      thr_q.push_back(last_thr);
    end
    pass_err = 0;
    href_seen = 0;
    in_vsync = 0;
    pass_exp = admit;
    watch = !admit;
    repeat (2) cyc_step();
    for (int l = 0; l < 4; l++) begin
      if (l == 1 && mid_en) enable = 1;
      if (l == 2 && mid_cfg >= 0) begin
        cfg_threshold = 8'(mid_cfg);
        cyc_step();
        check("thr_hold", sobel_threshold, last_thr);
      end
      for (int x = 0; x < 8; x++) begin
        in_href = 1;
        in_clken = !(drop && p == 31);
        in_img = {p < n_edge, 7'(p + l)};
        p++;
        cyc_step();
      end
      in_href = 0;
      in_clken = 0;
      in_img = 0;
      repeat (2) cyc_step();
    end
    in_vsync = 1;
    pass_exp = 0;
    watch = 0;
    if (!admit) check("skip_href", href_seen, 0);
    else begin
      check("passthru", pass_err, 0);
      if (tmo) res_q.push_back('{0, 1, m_ec, m_cnt});
      else begin
        err = drop;
        m_cnt++;
        m_ec = n_edge;
        res_q.push_back('{1, err, m_ec, m_cnt});
        if (!err) m_thr = auto_thr_en ? step_thr(m_thr, n_edge) : int'(cfg_threshold);
      end
    end
  endtask

  task automatic wait_empty();
    int b = 0;
    while (res_q.size() != 0 && b < 6000) begin
      cyc_step();
      b++;
    end
    check("wait_close", res_q.size(), 0);
  endtask

  initial begin
    rst = 1; enable = 0; auto_thr_en = 0; cfg_threshold = 64;
    in_vsync = 1; in_href = 0; in_clken = 0; in_img = 0;
    repeat (3) cyc_step();
    check("rst_out_vsync", out_vsync, 1);
    check("rst_out_href", out_href, 0);
    check("rst_out_clken", out_clken, 0);
    check("rst_out_img", out_img, 0);
    check("rst_thr", sobel_threshold, 64);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 0;
    repeat (2) cyc_step();
    check("idle_busy", busy, 0);
    drive_frame(5, 0, 0, 0, 1, -1);
    drive_frame(5, 0, 1, 0, 0, -1);
    wait_empty();
    drive_frame(5, 0, 1, 0, 0, -1);
    wait_empty();
    cfg_threshold = 50;
    drive_frame(7, 0, 1, 0, 0, 90);
    wait_empty();
    drive_frame(3, 0, 1, 0, 0, -1);
    wait_empty();
    thr_q.push_back(int'(cfg_threshold));
    in_vsync = 0;
    cyc_step();
    for (int x = 0; x < 8; x++) begin
      in_href = 1; in_clken = 1; in_img = 8'(x);
      cyc_step();
    end
    rst = 1;
    cyc_step();
    check("mid_rst_out_vsync", out_vsync, 1);
    check("mid_rst_out_href", out_href, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_edge_count", edge_count, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_thr", sobel_threshold, 64);
    rst = 0; enable = 0; in_vsync = 1; in_href = 0; in_clken = 0; in_img = 0;
    m_cnt = 0; m_ec = 0; m_thr = 64;
    repeat (12) cyc_step();
    enable = 1;
    auto_thr_en = 1;
    for (int f = 0; f < 47; f++) begin
      drive_frame(32, 0, 1, 0, 0, -1);
      wait_empty();
    end
    for (int f = 0; f < 58; f++) begin
      drive_frame(0, 0, 1, 0, 0, -1);
      wait_empty();
    end
    drive_frame(20, 1, 1, 0, 0, -1);
    wait_empty();
    hold_pv = 1;
    drive_frame(5, 0, 1, 1, 0, -1);
    wait_empty();
    hold_pv = 0;
    drive_frame(5, 0, 1, 0, 0, -1);
    wait_empty();
    repeat (4) cyc_step();
    check("thr_q_empty", thr_q.size(), 0);
    check("end_busy", busy, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level controller for the Sobel edge-detect datapath. It admits only whole camera frames into the `sobel` engine and holds the engine's threshold constant for the entire frame. It monitors the engine's output stream to count edge pixels and flag malformed frames. In auto mode it closes a per-frame loop that steps the threshold toward a target edge density. It sits between the camera/grey-scale front end and the `sobel` instance, and drives that instance's `per_frame_*`, `per_img` and `sobel_threshold` inputs.

## Interface
- `IMG_HDISP`, 9'd320: active pixels per line.
- `IMG_VDISP`, 8'd240: active lines per frame.
- `THR_INIT`, 8'd64: threshold after reset.
- `THR_MIN` / `THR_MAX`, 8'd16 / 8'd240: auto-threshold clamp bounds.
- `THR_STEP`, 8'd4: auto-threshold step per frame.
- `TARGET_LO` / `TARGET_HI`, 17'd3840 / 17'd11520: edge-count window, i.e. 5%–15% of 76800.
- `DRAIN_MAX`, 16'd4096: cycle limit for the output frame to close.
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request, level.
- `auto_thr_en` in 1: 1 = closed-loop threshold, 0 = use `cfg_threshold`.
- `cfg_threshold` in 8: software threshold.
- `in_vsync`, `in_href`, `in_clken` in 1 each: camera stream; vsync high = sync/blanking.
- `in_img` in 8: grey pixel.
- `out_vsync`, `out_href`, `out_clken` out 1 each: gated stream to the engine.
- `out_img` out 8: gated pixel to the engine.
- `sobel_threshold` out 8: per-frame threshold to the engine.
- `post_vsync`, `post_href`, `post_clken`, `post_bit` in 1 each: engine output.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse when an output frame closes.
- `frame_err` out 1: one-cycle pulse on a bad pixel count or drain timeout.
- `edge_count` out 17: edge pixels in the last closed frame.
- `frame_cnt` out 16: closed frames, wraps at 16'hFFFF→0.

## Operation
- **Edge detection.**
  - `vs_d` is `in_vsync` registered; input frame start is `vs_d & ~in_vsync` and input frame end is `~vs_d & in_vsync`.
  - `post_vsync` is registered the same way; the output frame ends on its rising edge.
- **FSM states:** IDLE, ARM, RUN, DRAIN.
  - **IDLE:** stays while `enable`=0 → ARM when `enable`=1.
  - **ARM:** waits for `in_vsync`=1 sampled, so the block never enters mid-frame. → RUN on that cycle. If `enable`=0 → IDLE.
  - **RUN:**
    - Passes the stream through.
    - On input frame start, loads the threshold shadow.
    - On input frame end → DRAIN.
    - `enable` deasserting mid-frame has no effect until frame end.
  - **DRAIN:**
    - Gated stream is held in blanking.
    - Waits for the `post_vsync` rising edge, then performs the frame close → ARM if `enable`=1, else IDLE.
    - If the drain counter reaches `DRAIN_MAX`, pulses `frame_err` without `frame_done` → ARM/IDLE likewise.
- **Gating.**
  - In RUN, `out_*` and `out_img` equal the `in_*` signals registered by one cycle.
  - In all other states: `out_vsync`=1, `out_href`=0, `out_clken`=0, `out_img`=0.
  - Frames whose vsync falls while in DRAIN or IDLE are skipped entirely.
- **Threshold.**
  - On frame start in RUN, `sobel_threshold` is loaded with `auto_thr_en ? thr_auto : cfg_threshold`.
  - It is otherwise held, so changes to `cfg_threshold` mid-frame take effect at the next frame.
- **Statistics.**
  - In RUN and DRAIN, `pix_acc` increments on `post_href & post_clken`.
  - `edge_acc` increments on `post_href & post_clken & post_bit`.
  - Both accumulators are 17 bits and saturate at 17'h1FFFF.
  - Both are cleared on entering RUN.
- **Frame close.** On the `post_vsync` rising edge in DRAIN:
  - `edge_count` ← `edge_acc`.
  - `frame_cnt` ← +1.
  - `frame_done` pulses.
  - `frame_err` also pulses if `pix_acc` ≠ `IMG_HDISP*IMG_VDISP`.
- **Auto threshold.** Updated at frame close when `auto_thr_en`=1:
  - `edge_acc` > `TARGET_HI` → `thr_auto` ← min(`thr_auto`+`THR_STEP`, `THR_MAX`).
  - `edge_acc` < `TARGET_LO` → `thr_auto` ← max(`thr_auto`−`THR_STEP`, `THR_MIN`).
  - Otherwise `thr_auto` is held.
  - Computed at 9 bits, so no wrap is possible.
  - When `auto_thr_en`=0, `thr_auto` ← `cfg_threshold` at each frame close, so switching to auto is bumpless.
  - If the close also flags a count error, `thr_auto` is not changed.
  - On drain timeout, `thr_auto` is not changed.

## Timing
- **Reset values:**
  - `out_vsync`=1; `out_href`, `out_clken`=0; `out_img`=0.
  - `sobel_threshold`=`THR_INIT`, `thr_auto`=`THR_INIT`.
  - `busy`=0, `frame_done`=0, `frame_err`=0.
  - `edge_count`=0, `frame_cnt`=0; state = IDLE.
- **Reset mid-frame:** the gated stream drops to blanking on the next edge and any partial frame is discarded.
- **Latencies:**
  - Pass-through: 1 cycle.
  - `sobel_threshold` changes on the same edge as the first `out_vsync`=0 of the frame.
  - `frame_done`, `edge_count` and `frame_cnt` are registered 1 cycle after the `post_vsync` rising sample.
- **Drain counter:** clears on entering DRAIN and counts every cycle.
- **Simultaneous events:**
  - Post frame close and drain timeout on the same cycle: the close wins, with no timeout error.
  - `enable` falling in ARM on the same cycle `in_vsync`=1: → IDLE.

## Test plan
1. IMG_HDISP=8, IMG_VDISP=4; `enable`=1; two frames; post side is a 6-cycle delayed copy of `out_*`, with `post_bit`=1 on 5 pixels → two `frame_done` pulses, `edge_count`=5, `frame_cnt`=2, no `frame_err`.
2. Raise `enable` mid-frame (`in_vsync`=0) → that frame gets `out_href`=0 throughout; the next frame passes with 1-cycle delay.
3. `auto_thr_en`=1, `THR_INIT`=64, TARGET_HI=10, all 32 post pixels edges → threshold 68, 72, … saturating at `THR_MAX`; then 0 edges → steps down by 4 to `THR_MIN`.
4. Change `cfg_threshold` 50→90 mid-frame (auto off) → `sobel_threshold` stays 50 until the next frame start, then becomes 90.
5. Post side drops 1 `post_clken` → `frame_err` and `frame_done` pulse together, `thr_auto` unchanged. Post side never raises vsync → `frame_err` after 4096 DRAIN cycles, no `frame_done`, → ARM.
6. Assert `rst` mid-RUN → next cycle `out_vsync`=1, `busy`=0, all counters 0, `sobel_threshold`=64.
